mul_err_sweeper: RTL and testbench
==================================

Name: mul_err_sweeper

Overview:
- Drives the tb side of if_multiplier and measures the error of any multiplier behind it, exact or approximate (e.g. dadda_8).
- After a start pulse it sweeps all 2^(2*WIDTH) operand pairs, one pair per clock.
- Each pair's returned product is compared with the exact product, and error statistics are accumulated.
- Used in characterisation benches and on FPGA to compare approximate variants.

Parameters:
- WIDTH, 8, operand width; must match the attached multiplier.
- CNT_W, 2*WIDTH+1, width of err_count.
- SUM_W, 4*WIDTH, width of sum_abs_err; it cannot overflow over a full sweep.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep.
- abort  input  1  stop the sweep, return to IDLE.
- busy  output  1  high in SWEEP and DRAIN.
- done  output  1  high from sweep completion until the next accepted start.
- err_count  output  CNT_W  number of pairs with a wrong product.
- sum_abs_err  output  SUM_W  sum of |approx - exact|.
- max_abs_err  output  2*WIDTH  largest |approx - exact|.
- worst_in1  output  WIDTH  in1 of the first pair reaching max_abs_err.
- worst_in2  output  WIDTH  in2 of that pair.
- muif  interface  if_multiplier.tb_side  drives in1/in2 (WIDTH each); reads out (2*WIDTH-1) and overflow (1).

Behaviour:
- Reset (async, n_rst low): FSM=IDLE, operand registers=0, muif.in1/in2=0, busy=0, done=0, all stats=0. Reset mid-sweep discards everything immediately.
- States and transitions:
  - IDLE: start moves to SWEEP.
  - SWEEP: leaves for DRAIN after the last pair.
  - DRAIN: 2 cycles, then DONE.
  - DONE: start moves to SWEEP.
  - abort in SWEEP or DRAIN moves to IDLE. The partial stats stay visible, done=0.
- Starting a sweep: on an accepted start (in IDLE or DONE), stats clear to 0, done drops, and the operand counters clear to 0 on the same edge.
- start in SWEEP or DRAIN is ignored. If start and abort are both high, abort wins.
- Sweep order: muif.in1 is the inner loop and counts 0..2^WIDTH-1. On its wrap, muif.in2 increments. The last pair is (2^WIDTH-1, 2^WIDTH-1).
- Operands are driven from registers. The multiplier is combinational.
- Pipeline:
  - Stage 1, same edge: capture approx = {overflow, out} as 2*WIDTH bits, exact = in1*in2, and the operands.
  - Stage 2: abs_err = |approx - exact|. If abs_err is nonzero, err_count += 1. sum_abs_err += abs_err. If abs_err is strictly greater than max_abs_err, update max_abs_err and worst_in1/worst_in2, so the first occurrence wins ties.
- Stage-1 valid is set only in SWEEP. DRAIN flushes both stages, then done=1 and busy=0.
- Latency: done rises 2^(2*WIDTH)+3 edges after the accepted-start edge: 65539 for WIDTH=8.
- Stats hold their values in DONE and IDLE.
- Arithmetic: the subtraction uses 2*WIDTH+1 bits, signed, before the absolute value. All accumulators are unsigned and non-saturating; their widths guarantee no wrap.

Decomposition:
- Package mul_err_pkg holds:
  - state_t enum (IDLE, SWEEP, DRAIN, DONE);
  - constant DRAIN_CYCLES=2;
  - function abs_diff(a, b) returning 2*WIDTH bits.
- One sub-module, err_accum: stage-2 accumulator with clear, valid, abs_err and operands in, stats out.
- if_multiplier gains a tb_side modport (outputs in1, in2; inputs out, overflow) if it is not already present.

Test Plan:
- Exact 8x8 stub, full sweep -> err_count=0, sum_abs_err=0, max_abs_err=0, done at edge 65539.
- Stub forcing product bit 0 to 0 -> err_count=16384, sum_abs_err=16384, max_abs_err=1, worst_in1=1, worst_in2=1.
- Stub returning exact+3 when in1=in2=255, else exact -> err_count=1, sum=3, max=3, worst=(255,255).
- Pulse start again during SWEEP at cycle 1000 -> ignored; done still at edge 65539 with unchanged results. abort at cycle 5000 -> IDLE next edge, busy=0, done=0, partial stats held.
- n_rst low mid-sweep -> all outputs 0 asynchronously. A new start after release gives the full, correct sweep.
- Back-to-back: start in DONE with a different stub -> stats clear on the start edge, new results match the new stub.

Source files
------------

// File: rtl/mul_err_pkg.sv
// mul_err_pkg
// Shared types and helpers for the multiplier error sweeper.
//   state_t      : sweeper FSM states
//   DRAIN_CYCLES : cycles spent in DRAIN after the stage-2 flush edge
//   abs_diff     : |a - b| for unsigned products up to MAX_PW bits
package mul_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DRAIN_CYCLES = 2;
    localparam int unsigned DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

    // Widest product supported (WIDTH up to 16); callers size-cast in and out.
    localparam int unsigned MAX_PW = 32;

    // Operands are zero-extended by one bit, so the signed difference is the
    // same as a 2*WIDTH+1 bit signed subtraction of the real products.
    function automatic logic [MAX_PW-1:0] abs_diff(input logic [MAX_PW-1:0] a,
                                                   input logic [MAX_PW-1:0] b);
        logic signed [MAX_PW:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[MAX_PW] ? MAX_PW'(-d) : MAX_PW'(d);
    endfunction

endpackage

// File: rtl/if_multiplier.sv
// if_multiplier
// Connection between a multiplier under test and whatever drives it.
//   in1, in2 : operands (WIDTH bits each)
//   out      : low 2*WIDTH-1 product bits
//   overflow : product MSB
// Modports: tb_side drives operands and reads the product,
//           dut_side is the multiplier's view.
interface if_multiplier #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic [2*WIDTH-2:0] out;
    logic               overflow;

    modport tb_side  (output in1, output in2, input  out, input  overflow);
    modport dut_side (input  in1, input  in2, output out, output overflow);
endinterface

// File: rtl/err_accum.sv
// err_accum
// Stage-2 error accumulator of the sweeper.
//   clk, n_rst       : clock, async active-low reset
//   i_clr            : synchronous clear of all statistics (wins over i_valid)
//   i_valid          : i_abs_err / i_in1 / i_in2 belong to a real sweep pair
//   i_abs_err        : |approx - exact| for the pair
//   i_in1, i_in2     : operands of the pair
//   o_err_count      : pairs with nonzero error
//   o_sum_abs_err    : sum of all errors
//   o_max_abs_err    : largest error seen
//   o_worst_in1/in2  : operands of the first pair that reached o_max_abs_err
module err_accum
    import mul_err_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 2*WIDTH+1,
    parameter int SUM_W = 4*WIDTH
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_clr,
    input  logic               i_valid,
    input  logic [2*WIDTH-1:0] i_abs_err,
    input  logic [WIDTH-1:0]   i_in1,
    input  logic [WIDTH-1:0]   i_in2,
    output logic [CNT_W-1:0]   o_err_count,
    output logic [SUM_W-1:0]   o_sum_abs_err,
    output logic [2*WIDTH-1:0] o_max_abs_err,
    output logic [WIDTH-1:0]   o_worst_in1,
    output logic [WIDTH-1:0]   o_worst_in2
);
    logic [CNT_W-1:0]   r_err_count;
    logic [SUM_W-1:0]   r_sum_abs_err;
    logic [2*WIDTH-1:0] r_max_abs_err;
    logic [WIDTH-1:0]   r_worst_in1;
    logic [WIDTH-1:0]   r_worst_in2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_count   <= '0;
            r_sum_abs_err <= '0;
            r_max_abs_err <= '0;
            r_worst_in1   <= '0;
            r_worst_in2   <= '0;
        end else if (i_clr) begin
            r_err_count   <= '0;
            r_sum_abs_err <= '0;
            r_max_abs_err <= '0;
            r_worst_in1   <= '0;
            r_worst_in2   <= '0;
        end else if (i_valid) begin
            if (i_abs_err != '0) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            r_sum_abs_err <= r_sum_abs_err + SUM_W'(i_abs_err);
            // Strictly greater: ties keep the earliest pair.
            if (i_abs_err > r_max_abs_err) begin
                r_max_abs_err <= i_abs_err;
                r_worst_in1   <= i_in1;
                r_worst_in2   <= i_in2;
            end
        end
    end

    assign o_err_count   = r_err_count;
    assign o_sum_abs_err = r_sum_abs_err;
    assign o_max_abs_err = r_max_abs_err;
    assign o_worst_in1   = r_worst_in1;
    assign o_worst_in2   = r_worst_in2;
endmodule

// File: rtl/mul_err_sweeper.sv
// mul_err_sweeper
// Sweeps every operand pair through an attached combinational multiplier
// (one pair per clock) and accumulates error statistics against the exact
// product.
//   clk, n_rst   : clock, async active-low reset
//   start        : begin a sweep (accepted in IDLE or DONE, abort wins)
//   abort        : leave SWEEP/DRAIN for IDLE, keeping partial statistics
//   busy         : high in SWEEP and DRAIN
//   done         : high from sweep completion until the next accepted start
//   err_count    : pairs with a wrong product
//   sum_abs_err  : sum of |approx - exact|
//   max_abs_err  : largest |approx - exact|
//   worst_in1/2  : operands of the first pair reaching max_abs_err
//   muif         : multiplier connection (drives in1/in2, reads out/overflow)
module mul_err_sweeper
    import mul_err_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 2*WIDTH+1,
    parameter int SUM_W = 4*WIDTH
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_count,
    output logic [SUM_W-1:0]   sum_abs_err,
    output logic [2*WIDTH-1:0] max_abs_err,
    output logic [WIDTH-1:0]   worst_in1,
    output logic [WIDTH-1:0]   worst_in2,
    if_multiplier.tb_side      muif
);
    localparam int PW = 2*WIDTH;

    state_t             r_state;
    logic [WIDTH-1:0]   r_in1;
    logic [WIDTH-1:0]   r_in2;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_busy;
    logic               r_done;

    // Stage 1 registers
    logic               r_v1;
    logic [PW-1:0]      r_approx;
    logic [PW-1:0]      r_exact;
    logic [WIDTH-1:0]   r_s1_in1;
    logic [WIDTH-1:0]   r_s1_in2;

    logic               w_start_ok;
    logic               w_last;
    logic [PW-1:0]      w_abs_err;

    assign w_start_ok = start && !abort && (r_state == IDLE || r_state == DONE);
    assign w_last     = &{r_in2, r_in1};
    assign w_abs_err  = PW'(abs_diff(MAX_PW'(r_approx), MAX_PW'(r_exact)));

    assign muif.in1 = r_in1;
    assign muif.in2 = r_in2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_in1       <= '0;
            r_in2       <= '0;
            r_drain_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_state <= SWEEP;
                        r_in1   <= '0;
                        r_in2   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        // in1 is the low half of one counter, so its wrap carries into in2.
                        {r_in2, r_in1} <= {r_in2, r_in1} + PW'(1);
                        if (w_last) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES)) begin
                        // Stage 2 absorbed the last pair on the first DRAIN edge;
                        // the count then covers DRAIN_CYCLES further cycles.
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_v1     <= 1'b0;
            r_approx <= '0;
            r_exact  <= '0;
            r_s1_in1 <= '0;
            r_s1_in2 <= '0;
        end else begin
            r_v1     <= (r_state == SWEEP) && !abort;
            r_approx <= {muif.overflow, muif.out};
            r_exact  <= PW'(r_in1) * PW'(r_in2);
            r_s1_in1 <= r_in1;
            r_s1_in2 <= r_in2;
        end
    end

    err_accum #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) u_accum (
        .clk           (clk),
        .n_rst         (n_rst),
        .i_clr         (w_start_ok),
        .i_valid       (r_v1),
        .i_abs_err     (w_abs_err),
        .i_in1         (r_s1_in1),
        .i_in2         (r_s1_in2),
        .o_err_count   (err_count),
        .o_sum_abs_err (sum_abs_err),
        .o_max_abs_err (max_abs_err),
        .o_worst_in1   (worst_in1),
        .o_worst_in2   (worst_in2)
    );

    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_mul_err_sweeper.sv
// tb_mul_err_sweeper
// Scoreboard bench for mul_err_sweeper at WIDTH=4 (256 pairs per sweep).
// A behavioural multiplier stub selected by 'mode' sits behind the interface:
//   0: exact, 1: product bit 0 forced low, 2: exact+3 only at (15,15).
module tb_mul_err_sweeper;
    localparam int          W     = 4;
    localparam int          PW    = 2*W;
    localparam int          CNT_W = 2*W+1;
    localparam int          SUM_W = 4*W;
    localparam int unsigned NPAIR = 1 << (2*W);
    localparam int unsigned LAT   = NPAIR + 3;
    localparam int unsigned ABORT_AT = 100;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   err_count;
    logic [SUM_W-1:0]   sum_abs_err;
    logic [PW-1:0]      max_abs_err;
    logic [W-1:0]       worst_in1;
    logic [W-1:0]       worst_in2;

    if_multiplier #(.WIDTH(W)) mi ();

    mul_err_sweeper #(
        .WIDTH (W),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err),
        .worst_in1   (worst_in1),
        .worst_in2   (worst_in2),
        .muif        (mi)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int mode = 0;
    logic [PW-1:0] w_p;
    always_comb begin
        w_p = PW'(mi.in1) * PW'(mi.in2);
        if (mode == 1) w_p[0] = 1'b0;
        if (mode == 2 && mi.in1 == 4'hF && mi.in2 == 4'hF) w_p = w_p + PW'(3);
        mi.out      = w_p[PW-2:0];
        mi.overflow = w_p[PW-1];
    end

    typedef struct {
        longint unsigned cnt;
        longint unsigned sum;
        longint unsigned mx;
        longint unsigned w1;
        longint unsigned w2;
        int unsigned     s;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    endtask

    function automatic exp_t mk(input longint unsigned c, input longint unsigned su,
                                input longint unsigned m, input longint unsigned a,
                                input longint unsigned b);
        exp_t e;
        e.cnt = c; e.sum = su; e.mx = m; e.w1 = a; e.w2 = b; e.s = 0;
        return e;
    endfunction

    // Monitor: every rising done consumes one expectation.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done rose at cycle %0d with no sweep expected", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("err_count",   err_count,   e.cnt);
                check("sum_abs_err", sum_abs_err, e.sum);
                check("max_abs_err", max_abs_err, e.mx);
                check("worst_in1",   worst_in1,   e.w1);
                check("worst_in2",   worst_in2,   e.w2);
                check("done_latency", cyc - e.s,  LAT);
                check("busy_at_done", busy, 0);
            end
        end
        prev_done = done;
    end

    task automatic do_start(input int m, input bit push, input exp_t e_in, output int unsigned s);
        exp_t e;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
        if (push) begin
            e   = e_in;
            e.s = s;
            q.push_back(e);
        end
    endtask

    task automatic wait_done(input string nm);
        int unsigned k = 0;
        while (!done && k < LAT + 20) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s_timeout: done still 0, required 1 within %0d cycles", nm, LAT + 20);
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   err_count, 0);
        check({tag, "_sum"},   sum_abs_err, 0);
        check({tag, "_max"},   max_abs_err, 0);
        check({tag, "_w1"},    worst_in1, 0);
        check({tag, "_w2"},    worst_in2, 0);
        check({tag, "_in1"},   mi.in1, 0);
        check({tag, "_in2"},   mi.in2, 0);
    endtask

    initial begin
        int unsigned s;
        int unsigned pcnt;
        exp_t none;
        none = mk(0, 0, 0, 0, 0);

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // Bit 0 forced low: odd*odd pairs are off by one, first at (1,1)
        do_start(1, 1'b1, mk(64, 64, 1, 1, 1), s);
        wait_done("bit0");

        // Back-to-back start from DONE with a new stub; stats clear on start edge
        do_start(2, 1'b1, mk(1, 3, 3, 15, 15), s);
        check("b2b_clr_err",  err_count, 0);
        check("b2b_clr_sum",  sum_abs_err, 0);
        check("b2b_clr_max",  max_abs_err, 0);
        check("b2b_clr_w1",   worst_in1, 0);
        check("b2b_done_low", done, 0);
        check("b2b_busy",     busy, 1);
        // Start pulse during SWEEP must be ignored
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("plus3");

        // Exact multiplier
        do_start(0, 1'b1, none, s);
        wait_done("exact");

        // Abort mid-sweep: pairs 0..ABORT_AT-2 reach stage 2 before IDLE
        do_start(1, 1'b0, none, s);
        repeat (ABORT_AT) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        pcnt = 0;
        for (int unsigned k = 0; k < ABORT_AT - 1; k++) begin
            if (((k % 16) & (k / 16) & 1) != 0) pcnt++;
        end
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err",  err_count, pcnt);
        check("abort_sum",  sum_abs_err, pcnt);
        check("abort_max",  max_abs_err, 1);
        repeat (5) @(negedge clk);
        check("abort_hold_err", err_count, pcnt);
        check("abort_hold_w1",  worst_in1, 1);
        check("abort_hold_w2",  worst_in2, 1);
        check("abort_hold_busy", busy, 0);

        // Async reset mid-sweep clears everything between clock edges
        do_start(1, 1'b0, none, s);
        repeat (50) @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        n_rst = 1'b1;

        // Full sweep after reset release
        do_start(2, 1'b1, mk(1, 3, 3, 15, 15), s);
        wait_done("after_reset");

        check("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
